// File: rtl/delay_arb_ctrl.sv
// Two-channel round-robin front end onto one programmable-depth delay line.
// Depth changes drain the line before the new depth takes effect.
module delay_arb_ctrl #(
   parameter int MAX_DEPTH = 8,
   parameter int RST_DEPTH = 3,
   parameter int DW        = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          a_valid,
   input  logic [24:0]   a_data,
   output logic          a_ready,
   input  logic          b_valid,
   input  logic [24:0]   b_data,
   output logic          b_ready,
   input  logic          cfg_wr,
   input  logic [DW-1:0] cfg_depth,
   output logic          cfg_busy,
   output logic [DW-1:0] cur_depth,
   output logic          out_valid,
   output logic [24:0]   out_data,
   output logic          out_ch
);

   localparam int CW = $clog2(MAX_DEPTH + 1);

   localparam logic [0:0] RUN   = 1'b0;
   localparam logic [0:0] DRAIN = 1'b1;

   typedef struct packed {
      logic        v;
      logic        ch;
      logic [24:0] d;
   } slot_t;

   slot_t [MAX_DEPTH-1:0] pipe_q, pipe_d;
   logic [0:0]    state_q, state_d;
   logic          last_q, last_d;
   logic [DW-1:0] depth_q, depth_d;
   logic [DW-1:0] pend_q, pend_d;
   logic [DW-1:0] clamp;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          run, acc, emit;
   int            ins;

   assign run     = (state_q == RUN);
   assign a_ready = run & a_valid & (~b_valid | last_q);
   assign b_ready = run & b_valid & (~a_valid | ~last_q);
   assign acc     = a_ready | b_ready;
   assign emit    = pipe_q[MAX_DEPTH-1].v;

   assign cfg_busy  = (state_q == DRAIN);
   assign cur_depth = depth_q;
   assign out_valid = pipe_q[MAX_DEPTH-1].v;
   assign out_data  = pipe_q[MAX_DEPTH-1].d;
   assign out_ch    = pipe_q[MAX_DEPTH-1].ch;

   always_comb begin
      clamp = cfg_depth;
      if (cfg_depth == '0)
         clamp = DW'(1);
      else if (int'(cfg_depth) > MAX_DEPTH)
         clamp = DW'(MAX_DEPTH);
   end

   // Samples enter D slots before the tail so they exit after D edges.
   always_comb begin
      ins    = MAX_DEPTH - int'(depth_q);
      pipe_d = '0;
      for (int i = 1; i < MAX_DEPTH; i++)
         pipe_d[i] = pipe_q[i-1];
      for (int i = 0; i < MAX_DEPTH; i++) begin
         if (acc && i == ins) begin
            pipe_d[i].v  = 1'b1;
            pipe_d[i].ch = b_ready;
            pipe_d[i].d  = b_ready ? b_data : a_data;
         end
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (acc && !emit)
         cnt_d = cnt_q + CW'(1);
      else if (!acc && emit)
         cnt_d = cnt_q - CW'(1);
   end

   always_comb begin
      last_d  = acc ? b_ready : last_q;
      state_d = state_q;
      depth_d = depth_q;
      pend_d  = pend_q;
      unique case (state_q)
         RUN: begin
            if (cfg_wr) begin
               pend_d  = clamp;
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (cnt_d == '0) begin
               depth_d = pend_q;
               state_d = RUN;
            end
         end
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pipe_q  <= '0;
         state_q <= RUN;
         last_q  <= 1'b1;
         depth_q <= DW'(RST_DEPTH);
         pend_q  <= DW'(RST_DEPTH);
         cnt_q   <= '0;
      end else begin
         pipe_q  <= pipe_d;
         state_q <= state_d;
         last_q  <= last_d;
         depth_q <= depth_d;
         pend_q  <= pend_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_delay_arb_ctrl.sv
// Bench for delay_arb_ctrl: a scheduled-exit model of the delay line
// predicts grants, outputs, in-flight count and configuration state.
module tb_delay_arb_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        a_valid, b_valid, cfg_wr;
   logic [24:0] a_data, b_data;
   logic [3:0]  cfg_depth;
   logic        a_ready, b_ready, cfg_busy;
   logic [3:0]  cur_depth;
   logic        out_valid, out_ch;
   logic [24:0] out_data;

   delay_arb_ctrl #(.MAX_DEPTH(8), .RST_DEPTH(3), .DW(4)) dut (
      .clk(clk), .reset(reset),
      .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
      .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
      .cfg_wr(cfg_wr), .cfg_depth(cfg_depth),
      .cfg_busy(cfg_busy), .cur_depth(cur_depth),
      .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int          due;
      logic [24:0] d;
      bit          ch;
   } ent_t;

   ent_t q[$];
   int   edge_n = 0;
   int   m_depth, m_pend;
   bit   m_drain, m_last;

   logic        obs_ar, obs_br, obs_busy, obs_ov, obs_och;
   logic [3:0]  obs_depth, obs_cnt;
   logic [24:0] obs_od;
   logic        exp_ar, exp_br, exp_busy, exp_ov, exp_och;
   logic [3:0]  exp_depth, exp_cnt;
   logic [24:0] exp_od;

   function automatic int inflight();
      int n = 0;
      foreach (q[i]) if (q[i].due >= edge_n) n++;
      return n;
   endfunction

   function automatic int clampd(input logic [3:0] cd);
      if (cd == 0) return 1;
      if (cd > 8) return 8;
      return int'(cd);
   endfunction

   task automatic model_reset();
      q.delete();
      m_depth = 3;
      m_pend  = 3;
      m_drain = 1'b0;
      m_last  = 1'b1;
   endtask

   task automatic step(input bit av, input logic [24:0] ad,
                       input bit bv, input logic [24:0] bd,
                       input bit cw, input logic [3:0] cd);
      @(negedge clk);
      a_valid = av; a_data = ad;
      b_valid = bv; b_data = bd;
      cfg_wr = cw; cfg_depth = cd;
      #1;
      obs_ar    = a_ready;
      obs_br    = b_ready;
      obs_busy  = cfg_busy;
      obs_depth = cur_depth;
      exp_busy  = m_drain;
      exp_depth = 4'(m_depth);
      exp_ar = !m_drain && av && (!bv || m_last);
      exp_br = !m_drain && bv && (!av || !m_last);
      @(posedge clk);
      edge_n++;
      if (exp_ar || exp_br) begin
         q.push_back('{edge_n + m_depth - 1, exp_br ? bd : ad, exp_br});
         m_last = exp_br;
      end
      if (m_drain) begin
         if (inflight() == 0) begin
            m_depth = m_pend;
            m_drain = 1'b0;
         end
      end else if (cw) begin
         m_pend  = clampd(cd);
         m_drain = 1'b1;
      end
      while (q.size() > 0 && q[0].due < edge_n) void'(q.pop_front());
      exp_ov = 1'b0; exp_od = '0; exp_och = 1'b0;
      if (q.size() > 0 && q[0].due == edge_n) begin
         exp_ov = 1'b1; exp_od = q[0].d; exp_och = q[0].ch;
      end
      exp_cnt = 4'(inflight());
      #1;
      obs_ov  = out_valid;
      obs_od  = out_data;
      obs_och = out_ch;
      obs_cnt = dut.cnt_q;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, '0, 0, '0, 0, '0);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      a_valid = 0; b_valid = 0; cfg_wr = 0;
      a_data = '0; b_data = '0; cfg_depth = '0;
      model_reset();
      repeat (3) @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || out_data !== '0 || out_ch !== 1'b0) begin
         errors++;
         $display("FAIL reset_out: got v=%b d=%0d ch=%b want 0/0/0",
                  out_valid, out_data, out_ch);
      end
      checks++;
      if (cfg_busy !== 1'b0 || cur_depth !== 4'd3 || dut.cnt_q !== 4'd0) begin
         errors++;
         $display("FAIL reset_cfg: got busy=%b depth=%0d cnt=%0d want 0/3/0",
                  cfg_busy, cur_depth, dut.cnt_q);
      end
      reset = 1'b0;
   endtask

   task automatic test_a_only();
      logic [24:0] vals [3];
      int nv = 0;
      vals[0] = 25'sd5;
      vals[1] = -25'sd7;
      vals[2] = 25'd16777215;
      for (int i = 0; i < 9; i++) begin
         if (i < 3) step(1, vals[i], 0, '0, 0, '0);
         else idle(1);
         if (obs_ar !== exp_ar || obs_br !== exp_br) begin
            errors++;
            $display("FAIL a_only_ready[%0d]: got %b%b want %b%b",
                     i, obs_ar, obs_br, exp_ar, exp_br);
         end
         checks++;
         if (obs_ov !== exp_ov || obs_od !== exp_od || obs_och !== exp_och) begin
            errors++;
            $display("FAIL a_only_out[%0d]: got %b/%0d/%b want %b/%0d/%b",
                     i, obs_ov, obs_od, obs_och, exp_ov, exp_od, exp_och);
         end
         checks++;
         if (obs_ov === 1'b1) nv++;
      end
      checks++;
      if (nv != 3) begin
         errors++;
         $display("FAIL a_only_count: got %0d valid cycles want 3", nv);
      end
   endtask

   task automatic test_alternate();
      for (int i = 0; i < 10; i++) begin
         if (i < 6) step(1, 25'($urandom), 1, 25'($urandom), 0, '0);
         else idle(1);
         if (obs_ar !== exp_ar || obs_br !== exp_br) begin
            errors++;
            $display("FAIL alt_grant[%0d]: got %b%b want %b%b",
                     i, obs_ar, obs_br, exp_ar, exp_br);
         end
         checks++;
         if (obs_ov !== exp_ov || obs_od !== exp_od || obs_och !== exp_och) begin
            errors++;
            $display("FAIL alt_out[%0d]: got %b/%0d/%b want %b/%0d/%b",
                     i, obs_ov, obs_od, obs_och, exp_ov, exp_od, exp_och);
         end
         checks++;
      end
   endtask

   task automatic run_checked(input string nm, input int n,
                              input bit av, input bit bv,
                              input bit cw, input logic [3:0] cd);
      for (int i = 0; i < n; i++) begin
         step(av, 25'($urandom), bv, 25'($urandom), cw, cd);
         if (obs_ar !== exp_ar || obs_br !== exp_br || obs_busy !== exp_busy) begin
            errors++;
            $display("FAIL %s_ctl[%0d]: got r=%b%b busy=%b want r=%b%b busy=%b",
                     nm, i, obs_ar, obs_br, obs_busy, exp_ar, exp_br, exp_busy);
         end
         checks++;
         if (obs_depth !== exp_depth || obs_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL %s_state[%0d]: got depth=%0d cnt=%0d want %0d/%0d",
                     nm, i, obs_depth, obs_cnt, exp_depth, exp_cnt);
         end
         checks++;
         if (obs_ov !== exp_ov || obs_od !== exp_od || obs_och !== exp_och) begin
            errors++;
            $display("FAIL %s_out[%0d]: got %b/%0d/%b want %b/%0d/%b",
                     nm, i, obs_ov, obs_od, obs_och, exp_ov, exp_od, exp_och);
         end
         checks++;
      end
   endtask

   task automatic test_cfg_drain();
      run_checked("drain_fill", 3, 1, 0, 0, '0);
      run_checked("drain_wr", 1, 1, 0, 1, 4'd1);
      run_checked("drain_wait", 6, 1, 1, 0, '0);
      checks++;
      if (cur_depth !== 4'd1 || cfg_busy !== 1'b0) begin
         errors++;
         $display("FAIL drain_done: got depth=%0d busy=%b want 1/0",
                  cur_depth, cfg_busy);
      end
      run_checked("drain_d1", 3, 1, 0, 0, '0);
   endtask

   task automatic test_clamp();
      run_checked("clamp0", 3, 0, 0, 1, 4'd0);
      checks++;
      if (cur_depth !== 4'd1) begin
         errors++;
         $display("FAIL clamp_zero: got %0d want 1", cur_depth);
      end
      run_checked("clamp_fill", 1, 1, 0, 0, '0);
      run_checked("clamp15", 1, 0, 0, 1, 4'd15);
      run_checked("clamp_ign", 1, 0, 0, 1, 4'd5);
      run_checked("clamp_idle", 3, 0, 0, 0, '0);
      checks++;
      if (cur_depth !== 4'd8) begin
         errors++;
         $display("FAIL clamp_max: got %0d want 8", cur_depth);
      end
   endtask

   task automatic test_reset_mid();
      bit seen = 1'b0;
      run_checked("rmid_fill", 2, 1, 0, 0, '0);
      run_checked("rmid_wr", 1, 0, 0, 1, 4'd2);
      for (int i = 0; i < 20 && !seen; i++) begin
         idle(1);
         if (obs_ov === 1'b1) seen = 1'b1;
      end
      checks++;
      if (!seen || cfg_busy !== 1'b1) begin
         errors++;
         $display("FAIL rmid_pre: got seen=%b busy=%b want 1/1", seen, cfg_busy);
      end
      reset = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_data !== '0 || cfg_busy !== 1'b0) begin
         errors++;
         $display("FAIL rmid_async: got v=%b d=%0d busy=%b want 0/0/0",
                  out_valid, out_data, cfg_busy);
      end
      model_reset();
      @(negedge clk);
      reset = 1'b0;
      checks++;
      if (cur_depth !== 4'd3 || dut.cnt_q !== 4'd0) begin
         errors++;
         $display("FAIL rmid_state: got depth=%0d cnt=%0d want 3/0",
                  cur_depth, dut.cnt_q);
      end
      step(1, 25'd11, 1, 25'd22, 0, '0);
      checks++;
      if (obs_ar !== 1'b1 || obs_br !== 1'b0) begin
         errors++;
         $display("FAIL rmid_prio: got %b%b want 10", obs_ar, obs_br);
      end
      run_checked("rmid_tail", 4, 0, 0, 0, '0);
   endtask

   task automatic test_depth1_stream();
      run_checked("d1_set", 4, 0, 0, 1, 4'd1);
      run_checked("d1_run", 5, 1, 0, 0, '0);
      checks++;
      if (obs_cnt !== 4'd1) begin
         errors++;
         $display("FAIL d1_hold: got cnt=%0d want 1", obs_cnt);
      end
      run_checked("d1_wr", 1, 1, 0, 1, 4'd2);
      run_checked("d1_drain", 4, 1, 0, 0, '0);
      checks++;
      if (cur_depth !== 4'd2) begin
         errors++;
         $display("FAIL d1_new: got %0d want 2", cur_depth);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         bit cw = ($urandom_range(0, 15) == 0);
         run_checked("rand", 1, 1'($urandom), 1'($urandom),
                     cw, 4'($urandom));
      end
      run_checked("rand_flush", 12, 0, 0, 0, '0);
   endtask

   initial begin
      test_reset();
      test_a_only();
      test_alternate();
      test_cfg_drain();
      test_clamp();
      test_reset_mid();
      test_depth1_stream();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/delay_arb_ctrl.md
Name: delay_arb_ctrl

Overview:
- Shares one programmable-depth delay pipeline (25-bit signed samples) between two requesting channels, A and B.
- Round-robin arbitration admits at most one sample per cycle. Each sample is tagged with its source channel and emitted after the programmed delay.
- Depth changes are sequenced safely by draining in-flight samples before the new depth is applied.
- Sits between the filter datapath stages that need aligned delays and the downstream consumer.

Parameters:
- MAX_DEPTH, 8, maximum delay in cycles (>=1).
- RST_DEPTH, 3, depth after reset (1..MAX_DEPTH).
- DW, 4, width of cfg_depth; must hold MAX_DEPTH.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- a_valid  in  1  channel A sample valid.
- a_data  in  25  channel A signed sample.
- a_ready  out  1  channel A sample accepted this cycle (when a_valid is also high).
- b_valid  in  1  channel B sample valid.
- b_data  in  25  channel B signed sample.
- b_ready  out  1  channel B sample accepted this cycle (when b_valid is also high).
- cfg_wr  in  1  depth write strobe.
- cfg_depth  in  DW  requested delay depth.
- cfg_busy  out  1  high while in DRAIN state.
- cur_depth  out  DW  depth currently applied.
- out_valid  out  1  delayed sample valid.
- out_data  out  25  delayed signed sample.
- out_ch  out  1  source of out_data: 0 = A, 1 = B.

Behaviour:
- Reset:
  - Asynchronous, active-high; clock clk.
  - Clears all stages, so out_valid=0, out_data=0 and out_ch=0.
  - State is RUN, cur_depth=RST_DEPTH, in-flight count=0.
  - Round-robin pointer last=B, so A wins the first contention.
  - Reset mid-operation discards all in-flight samples and any pending configuration.
- States: RUN, DRAIN.
- Arbitration (RUN only; ready is combinational on the valids and state):
  - Only A valid: a_ready=1.
  - Only B valid: b_ready=1.
  - Both valid: grant the channel that is not `last`.
  - A grant updates `last` to the granted channel on the accepting edge.
  - In DRAIN: a_ready=b_ready=0.
  - Ready never asserts while the corresponding valid is low.
- Latency:
  - A sample accepted at edge t appears on out_* in the cycle after edge t+D-1, where D=cur_depth.
  - D=1 is a single register; D=3 is three registers.
  - Exactly one out_valid cycle per accepted sample.
  - Data is passed unmodified; sign is preserved.
- Bubbles: cycles with no accept propagate zeros. out_data=0 and out_ch=0 whenever out_valid=0.
- No output backpressure: the pipeline never stalls.
- In-flight counter (width holds 0..MAX_DEPTH):
  - +1 on accept, -1 on each out_valid cycle.
  - Simultaneous accept and emit leaves it unchanged.
- Configuration:
  - cfg_wr in RUN is accepted: the requested value is latched as pending and the state becomes DRAIN on the next edge.
  - cfg_wr while cfg_busy=1 is ignored.
  - Clamping: cfg_depth=0 is treated as 1; values >MAX_DEPTH are treated as MAX_DEPTH.
  - In DRAIN the pipeline keeps shifting. When the in-flight count is 0 (counting an emit in that same cycle), cur_depth takes the pending value and the state returns to RUN on that edge.
  - DRAIN lasts at least one cycle, even when the pipeline is already empty.
  - cfg_wr and a valid input in the same RUN cycle: the input is accepted (ready is based on the current state) and drains before the new depth applies.
  - Writing the same depth still goes through DRAIN.
- Samples accepted before a depth change always exit with the old depth. The new depth applies only to samples accepted after returning to RUN.

Test Plan:
1. Reset, then A only sends 5, -7, 16777215 (max positive) on consecutive cycles at depth 3. Required: a_ready=1 on each; out_data 5, -7, 16777215 with out_ch=0 appear 3 edges after each accept; out_valid high for exactly 3 cycles.
2. A and B both valid continuously for 6 cycles. Required: grants alternate A,B,A,B,A,B starting with A after reset; out_ch alternates 0,1,0,1,0,1 at depth 3.
3. 3 samples in flight at depth 3, then cfg_wr with cfg_depth=1. Required: cfg_busy=1; both ready low until the 3 samples exit with their original latency; cur_depth=1; the next sample appears 1 edge after accept.
4. cfg_depth=0, then cfg_depth=15 with MAX_DEPTH=8. Required: cur_depth becomes 1 and then 8. A cfg_wr pulsed while cfg_busy=1 leaves the pending value unchanged.
5. Assert reset while 2 samples are in flight and in DRAIN. Required: out_valid=0 immediately (asynchronous); after release state is RUN, cur_depth=3, and A has priority on contention.
6. Depth 1 with continuous A-only traffic. Required: in-flight counter holds at 1 through simultaneous accept/emit; a cfg_wr issued then waits until the counter reaches 0 before cur_depth updates.
